// File: rtl/level_judge_if.sv
// Signal bundle between the level counter/timer logic and the level judge.
// The judge attaches through the slave modport; the event source uses master.
interface level_judge_if #(
  parameter int DIFF_W  = 5,
  parameter int LEVEL_W = 3,
  parameter int LIFE_W  = 2,
  parameter int SCORE_W = 8
) ();
  logic               start;
  logic               levelComplete;
  logic [DIFF_W-1:0]  difference;
  logic               timerExpired;
  logic               incLevel;
  logic               retryLevel;
  logic               lose;
  logic               win;
  logic               playing;
  logic [LEVEL_W-1:0] level;
  logic [LIFE_W-1:0]  livesLeft;
  logic [SCORE_W-1:0] score;

  modport master (
    output start, levelComplete, difference, timerExpired,
    input  incLevel, retryLevel, lose, win, playing, level, livesLeft, score
  );

  modport slave (
    input  start, levelComplete, difference, timerExpired,
    output incLevel, retryLevel, lose, win, playing, level, livesLeft, score
  );
endinterface

// File: rtl/level_judge.sv
// Multi-level game judge: tracks level, lives and a saturating score, and
// decides win/lose. Every output comes straight from a flop.
module level_judge #(
  parameter int DIFF_W        = 5,
  parameter int NUM_LEVELS    = 8,
  parameter int LEVEL_W       = 3,
  parameter int MAX_LIVES     = 3,
  parameter int LIFE_W        = 2,
  parameter int TOLERANCE     = 0,
  parameter int PERFECT_BONUS = 2,
  parameter int SCORE_W       = 8
) (
  input logic          Clk100M,
  input logic          reset,
  level_judge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_e;

  localparam logic [31:0]        TOL_U      = 32'(TOLERANCE);
  localparam logic [31:0]        SCORE_MAX  = (32'd1 << SCORE_W) - 32'd1;
  localparam logic [31:0]        PERFECT_PT = 32'(PERFECT_BONUS) + 32'd1;
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(MAX_LIVES);

  state_e             state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIFE_W-1:0]  lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               inc_q, inc_d;
  logic               retry_q, retry_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;
  logic               playing_q, playing_d;

  logic        diff_ok;
  logic        judging;
  logic        pass_ev;
  logic        fail_ev;
  logic [31:0] points;
  logic [31:0] score_sum;

  // start overrides everything, and a submission masks a same-cycle timeout
  assign diff_ok   = 32'(bus.difference) <= TOL_U;
  assign judging   = !bus.start && (state_q == PLAY);
  assign pass_ev   = judging && bus.levelComplete && diff_ok;
  assign fail_ev   = judging && ((bus.levelComplete && !diff_ok) ||
                                 (!bus.levelComplete && bus.timerExpired));
  assign points    = (bus.difference == '0) ? PERFECT_PT : 32'd1;
  assign score_sum = 32'(score_q) + points;

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= '0;
      lives_q   <= LIVES_INIT;
      score_q   <= '0;
      inc_q     <= 1'b0;
      retry_q   <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      inc_q     <= inc_d;
      retry_q   <= retry_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
      playing_q <= playing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    score_d = score_q;
    if (bus.start) begin
      state_d = PLAY;
      level_d = '0;
      lives_d = LIVES_INIT;
      score_d = '0;
    end else if (pass_ev) begin
      score_d = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0]
                                        : score_sum[SCORE_W-1:0];
      if (level_q < LAST_LEVEL) begin
        level_d = level_q + LEVEL_W'(1);
      end else begin
        state_d = WIN;
      end
    end else if (fail_ev) begin
      if (lives_q > LIFE_W'(1)) begin
        lives_d = lives_q - LIFE_W'(1);
      end else begin
        lives_d = '0;
        state_d = LOSE;
      end
    end
  end

  always_comb begin
    inc_d     = pass_ev;
    retry_d   = fail_ev && (lives_q > LIFE_W'(1));
    win_d     = (state_d == WIN);
    lose_d    = (state_d == LOSE);
    playing_d = (state_d == PLAY);
  end

  assign bus.incLevel   = inc_q;
  assign bus.retryLevel = retry_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;
  assign bus.playing    = playing_q;
  assign bus.level      = level_q;
  assign bus.livesLeft  = lives_q;
  assign bus.score      = score_q;

endmodule

// File: tb/tb_level_judge.sv
// Testbench for level_judge: a default instance and a narrow-score, wider-tolerance
// instance share one input stream and are compared with an abstract game model.
module tb_level_judge;

  localparam int NLEV   = 8;
  localparam int LIVES  = 3;
  localparam int BONUS  = 2;
  localparam int TOL_A  = 0;
  localparam int TOL_B  = 2;
  localparam int SMAX_A = 255;
  localparam int SMAX_B = 15;

  logic Clk100M = 1'b0;
  logic reset   = 1'b1;
  always #5 Clk100M = ~Clk100M;

  level_judge_if #(.SCORE_W(8)) ifa ();
  level_judge_if #(.SCORE_W(4)) ifb ();

  assign ifb.start         = ifa.start;
  assign ifb.levelComplete = ifa.levelComplete;
  assign ifb.difference    = ifa.difference;
  assign ifb.timerExpired  = ifa.timerExpired;

  level_judge #(.TOLERANCE(TOL_A), .SCORE_W(8)) dutA (
    .Clk100M(Clk100M), .reset(reset), .bus(ifa.slave));
  level_judge #(.TOLERANCE(TOL_B), .SCORE_W(4)) dutB (
    .Clk100M(Clk100M), .reset(reset), .bus(ifb.slave));

  // game state as plain integers: 0 idle, 1 play, 2 win, 3 lose
  typedef struct {
    int st; int level; int lives; int score; bit inc; bit retry;
  } mdl_t;

  typedef struct {
    bit rst; bit st; bit lc; bit te; logic [4:0] diff;
    bit inc; bit retry; bit lose; bit win; bit play;
    int level; int lives; int score;
  } vec_t;

  mdl_t ma, mb;
  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic mdl_t mstep(mdl_t m, bit r, bit s, bit lc, bit te, int d,
                                 int tol, int smax);
    mdl_t n = m;
    n.inc = 0;
    n.retry = 0;
    if (r) begin
      n.st = 0; n.level = 0; n.lives = LIVES; n.score = 0;
    end else if (s) begin
      n.st = 1; n.level = 0; n.lives = LIVES; n.score = 0;
    end else if (m.st == 1 && lc && d <= tol) begin
      n.inc = 1;
      n.score = m.score + 1 + ((d == 0) ? BONUS : 0);
      if (n.score > smax) n.score = smax;
      if (m.level < NLEV - 1) n.level = m.level + 1;
      else n.st = 2;
    end else if (m.st == 1 && (lc || te)) begin
      if (m.lives > 1) begin
        n.lives = m.lives - 1; n.retry = 1;
      end else begin
        n.lives = 0; n.st = 3;
      end
    end
    return n;
  endfunction

  function automatic logic [28:0] sig(logic inc, logic retry, logic lose, logic win,
                                      logic play, logic [7:0] lvl, logic [7:0] lv,
                                      logic [7:0] sc);
    return {inc, retry, lose, win, play, lvl, lv, sc};
  endfunction

  function automatic logic [28:0] mdlSig(mdl_t m);
    return sig(m.inc, m.retry, m.st == 3, m.st == 2, m.st == 1,
               8'(m.level), 8'(m.lives), 8'(m.score));
  endfunction

  function automatic vec_t mk(bit r, bit s, bit lc, bit te, int d, bit inc, bit retry,
                              bit lose, bit win, bit play, int lvl, int lv, int sc);
    vec_t v;
    v.rst = r; v.st = s; v.lc = lc; v.te = te; v.diff = 5'(d);
    v.inc = inc; v.retry = retry; v.lose = lose; v.win = win; v.play = play;
    v.level = lvl; v.lives = lv; v.score = sc;
    return v;
  endfunction

  task automatic compareSig(string name, logic [28:0] act, logic [28:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got inc,retry,lose,win,play=%b level=%0d lives=%0d score=%0d; want %b level=%0d lives=%0d score=%0d",
               name, act[28:24], act[23:16], act[15:8], act[7:0],
               exp[28:24], exp[23:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic compareInt(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(bit r, bit s, bit lc, bit te, logic [4:0] d);
    @(negedge Clk100M);
    reset             = r;
    ifa.start         = s;
    ifa.levelComplete = lc;
    ifa.timerExpired  = te;
    ifa.difference    = d;
    @(posedge Clk100M);
    #1;
    ma = mstep(ma, r, s, lc, te, int'(d), TOL_A, SMAX_A);
    mb = mstep(mb, r, s, lc, te, int'(d), TOL_B, SMAX_B);
  endtask

  task automatic checkOutput(string tag);
    compareSig({tag, " A"}, sig(ifa.incLevel, ifa.retryLevel, ifa.lose, ifa.win,
               ifa.playing, 8'(ifa.level), 8'(ifa.livesLeft), 8'(ifa.score)), mdlSig(ma));
    compareSig({tag, " B"}, sig(ifb.incLevel, ifb.retryLevel, ifb.lose, ifb.win,
               ifb.playing, 8'(ifb.level), 8'(ifb.livesLeft), 8'(ifb.score)), mdlSig(mb));
  endtask

  initial begin
    ifa.start = 0; ifa.levelComplete = 0; ifa.timerExpired = 0; ifa.difference = '0;
    ma = '{st: 0, level: 0, lives: LIVES, score: 0, inc: 0, retry: 0};
    mb = ma;

    // expected values below are for the default instance (TOLERANCE 0, 8-bit score)
    tbl.push_back(mk(1,0,0,0,0,  0,0,0,0,0, 0,3,0));
    tbl.push_back(mk(0,0,1,0,0,  0,0,0,0,0, 0,3,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,0,0,1, 0,3,0));
    tbl.push_back(mk(0,0,1,0,0,  1,0,0,0,1, 1,3,3));
    tbl.push_back(mk(0,0,0,0,0,  0,0,0,0,1, 1,3,3));
    tbl.push_back(mk(0,0,1,0,5,  0,1,0,0,1, 1,2,3));
    tbl.push_back(mk(0,0,0,1,0,  0,1,0,0,1, 1,1,3));
    tbl.push_back(mk(0,0,1,1,0,  1,0,0,0,1, 2,1,6));
    tbl.push_back(mk(0,0,1,0,1,  0,0,1,0,0, 2,0,6));
    tbl.push_back(mk(0,0,1,0,0,  0,0,1,0,0, 2,0,6));
    tbl.push_back(mk(0,1,1,0,0,  0,0,0,0,1, 0,3,0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0,0,1,0,0, 1,0,0,k == 8,k < 8, (k < 8) ? k : 7, 3, 3 * k));
    tbl.push_back(mk(0,0,1,0,0,  0,0,0,1,0, 7,3,24));
    tbl.push_back(mk(0,0,0,1,0,  0,0,0,1,0, 7,3,24));
    tbl.push_back(mk(0,1,0,0,0,  0,0,0,0,1, 0,3,0));
    for (int k = 1; k <= 4; k++)
      tbl.push_back(mk(0,0,1,0,0, 1,0,0,0,1, k, 3, 3 * k));
    tbl.push_back(mk(1,0,1,0,0,  0,0,0,0,0, 0,3,0));
    tbl.push_back(mk(0,1,0,0,0,  0,0,0,0,1, 0,3,0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].st, tbl[i].lc, tbl[i].te, tbl[i].diff);
      compareSig($sformatf("tbl[%0d]", i),
                 sig(ifa.incLevel, ifa.retryLevel, ifa.lose, ifa.win, ifa.playing,
                     8'(ifa.level), 8'(ifa.livesLeft), 8'(ifa.score)),
                 sig(tbl[i].inc, tbl[i].retry, tbl[i].lose, tbl[i].win, tbl[i].play,
                     8'(tbl[i].level), 8'(tbl[i].lives), 8'(tbl[i].score)));
      checkOutput($sformatf("mdl[%0d]", i));
    end

    // difference 2 passes only where tolerance is 2
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 2);
    compareInt("tol B inc", int'(ifb.incLevel), 1);
    compareInt("tol B score", int'(ifb.score), 1);
    compareInt("tol A retry", int'(ifa.retryLevel), 1);
    compareInt("tol A lives", int'(ifa.livesLeft), 2);
    applyStimulus(0, 0, 0, 0, 0);
    compareInt("pulse drop A", int'(ifa.retryLevel), 0);
    compareInt("pulse drop B", int'(ifb.incLevel), 0);

    // 4-bit score saturates at 15 and holds there
    applyStimulus(0, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(0, 0, 1, 0, 0);
      compareInt($sformatf("sat B score %0d", k), int'(ifb.score), (3 * k > 15) ? 15 : 3 * k);
      compareInt($sformatf("sat A score %0d", k), int'(ifa.score), 3 * k);
      checkOutput($sformatf("sat[%0d]", k));
    end

    for (int n = 0; n < 800; n++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, d);
      checkOutput($sformatf("rnd[%0d]", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
